// File: rtl/axi_default_param_pkg.sv
// Default AXI4 channel and bundle types for the grid manager-side port.
// 64-bit data, 32-bit address, 4-bit id, 1-bit user.
package axi_default_param_pkg;

   localparam int unsigned IdWidth   = 4;
   localparam int unsigned AddrWidth = 32;
   localparam int unsigned DataWidth = 64;
   localparam int unsigned UserWidth = 1;

   typedef logic [IdWidth-1:0]     mni_id_t;
   typedef logic [AddrWidth-1:0]   mni_addr_t;
   typedef logic [DataWidth-1:0]   mni_data_t;
   typedef logic [DataWidth/8-1:0] mni_strb_t;
   typedef logic [UserWidth-1:0]   mni_user_t;

   typedef struct packed {
      mni_id_t   id;
      mni_addr_t addr;
      logic [7:0] len;
      logic [2:0] size;
      logic [1:0] burst;
      logic       lock;
      logic [3:0] cache;
      logic [2:0] prot;
      logic [3:0] qos;
      logic [3:0] region;
      mni_user_t  user;
   } mni_ax_chan_t;

   typedef struct packed {
      mni_data_t data;
      mni_strb_t strb;
      logic      last;
      mni_user_t user;
   } mni_w_chan_t;

   typedef struct packed {
      mni_id_t    id;
      logic [1:0] resp;
      mni_user_t  user;
   } mni_b_chan_t;

   typedef struct packed {
      mni_id_t    id;
      mni_data_t  data;
      logic [1:0] resp;
      logic       last;
      mni_user_t  user;
   } mni_r_chan_t;

   typedef struct packed {
      mni_ax_chan_t aw;
      logic         aw_valid;
      mni_w_chan_t  w;
      logic         w_valid;
      logic         b_ready;
      mni_ax_chan_t ar;
      logic         ar_valid;
      logic         r_ready;
   } mni_req_t;

   typedef struct packed {
      logic        aw_ready;
      logic        ar_ready;
      logic        w_ready;
      logic        b_valid;
      mni_b_chan_t b;
      logic        r_valid;
      mni_r_chan_t r;
   } mni_resp_t;

endpackage

// File: rtl/axi_mem_sub.sv
// AXI4 subordinate backed by byte-addressable on-chip memory.
// Independent write/read FSMs, one outstanding burst per path.
module axi_mem_sub #(
   parameter type req_t  = axi_default_param_pkg::mni_req_t,
   parameter type resp_t = axi_default_param_pkg::mni_resp_t,
   parameter int  MEM_BYTES = 4096
) (
   input  logic  clk_i,
   input  logic  rst_i,
   input  req_t  req_i,
   output resp_t resp_o
);

   localparam int DATA_WIDTH = $bits(resp_o.r.data);
   localparam int NB         = DATA_WIDTH / 8;
   localparam int LANE_W     = $clog2(NB);
   localparam int OFF_W      = $clog2(MEM_BYTES);
   localparam int WORDS      = MEM_BYTES / NB;
   localparam int AW         = $bits(req_i.aw.addr);
   localparam int IW         = $bits(req_i.aw.id);

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_DATA = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;
   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_DATA = 1'b1;

   logic [NB-1:0][7:0] mem [WORDS];

   function automatic logic [AW-1:0] step_of(input logic [2:0] size);
      return AW'(1) << size;
   endfunction

   function automatic logic [AW-1:0] next_addr(
      input logic [AW-1:0] a,
      input logic [7:0]    len,
      input logic [2:0]    size,
      input logic [1:0]    burst
   );
      logic [AW-1:0] step;
      logic [AW-1:0] mask;
      logic [AW-1:0] nxt;
      step = step_of(size);
      mask = (AW'(len) + AW'(1)) * step - AW'(1);
      unique case (burst)
         2'b01:   nxt = (a & ~(step - AW'(1))) + step;
         2'b10:   nxt = (a & ~mask) | ((a + step) & mask);
         default: nxt = a;
      endcase
      return nxt;
   endfunction

   function automatic logic dec_err(
      input logic [AW-1:0] a,
      input logic [7:0]    len,
      input logic [2:0]    size,
      input logic [1:0]    burst
   );
      logic e;
      e = (burst == 2'b11) || (int'(size) > LANE_W);
      if (burst == 2'b10) begin
         e = e || !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
         e = e || ((a & (step_of(size) - AW'(1))) != '0);
      end
      return e;
   endfunction

   // Lanes covered by one beat: the size-aligned window holding the address.
   function automatic logic [NB-1:0] lane_mask(
      input logic [AW-1:0] a,
      input logic [2:0]    size
   );
      logic [NB-1:0] m;
      int span;
      int base;
      span = 1 << size;
      base = int'(a[LANE_W-1:0]) & ~(span - 1);
      for (int l = 0; l < NB; l++) begin
         m[l] = (l >= base) && (l < base + span);
      end
      return m;
   endfunction

   logic [1:0]      w_state;
   logic [IW-1:0]   w_id;
   logic [AW-1:0]   w_addr;
   logic [7:0]      w_len;
   logic [7:0]      w_cnt;
   logic [2:0]      w_size;
   logic [1:0]      w_burst;
   logic            w_bad;
   logic            w_err;
   logic            w_last_beat;
   logic            w_we;
   logic [NB-1:0]   w_be;
   logic [OFF_W-LANE_W-1:0] w_widx;

   assign w_last_beat = (w_cnt == w_len);
   assign w_we   = (w_state == W_DATA) && req_i.w_valid && !w_bad && !rst_i;
   assign w_be   = req_i.w.strb & lane_mask(w_addr, w_size);
   assign w_widx = w_addr[OFF_W-1:LANE_W];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         w_state <= W_IDLE;
         w_id    <= '0;
         w_addr  <= '0;
         w_len   <= '0;
         w_cnt   <= '0;
         w_size  <= '0;
         w_burst <= '0;
         w_bad   <= 1'b0;
         w_err   <= 1'b0;
      end else begin
         unique case (w_state)
            W_IDLE: if (req_i.aw_valid) begin
               w_id    <= req_i.aw.id;
               w_addr  <= req_i.aw.addr;
               w_len   <= req_i.aw.len;
               w_size  <= req_i.aw.size;
               w_burst <= req_i.aw.burst;
               w_bad   <= dec_err(req_i.aw.addr, req_i.aw.len,
                                  req_i.aw.size, req_i.aw.burst);
               w_err   <= dec_err(req_i.aw.addr, req_i.aw.len,
                                  req_i.aw.size, req_i.aw.burst);
               w_cnt   <= '0;
               w_state <= W_DATA;
            end
            W_DATA: if (req_i.w_valid) begin
               w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
               w_cnt  <= w_cnt + 8'd1;
               if (req_i.w.last != w_last_beat) w_err <= 1'b1;
               if (w_last_beat) w_state <= W_RESP;
            end
            W_RESP: if (req_i.b_ready) w_state <= W_IDLE;
            default: w_state <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_we) begin
         for (int l = 0; l < NB; l++) begin
            if (w_be[l]) mem[w_widx][l] <= req_i.w.data[8*l +: 8];
         end
      end
   end

   logic [0:0]            r_state;
   logic [IW-1:0]         r_id;
   logic [AW-1:0]         r_addr;
   logic [7:0]            r_len;
   logic [7:0]            r_cnt;
   logic [2:0]            r_size;
   logic [1:0]            r_burst;
   logic                  r_err;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  ar_err;
   logic [AW-1:0]         rd_addr;
   logic [2:0]            rd_size;
   logic                  rd_err;
   logic [NB-1:0]         rd_be;
   logic [DATA_WIDTH-1:0] rd_word;

   assign ar_err = dec_err(req_i.ar.addr, req_i.ar.len,
                           req_i.ar.size, req_i.ar.burst);

   // Beat data is captured into a register so R stays stable under stall.
   always_comb begin
      rd_addr = req_i.ar.addr;
      rd_size = req_i.ar.size;
      rd_err  = ar_err;
      if (r_state == R_DATA) begin
         rd_addr = next_addr(r_addr, r_len, r_size, r_burst);
         rd_size = r_size;
         rd_err  = r_err;
      end
      rd_be   = lane_mask(rd_addr, rd_size);
      rd_word = '0;
      for (int l = 0; l < NB; l++) begin
         if (rd_be[l] && !rd_err) begin
            rd_word[8*l +: 8] = mem[rd_addr[OFF_W-1:LANE_W]][l];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= R_IDLE;
         r_id    <= '0;
         r_addr  <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_size  <= '0;
         r_burst <= '0;
         r_err   <= 1'b0;
         r_data  <= '0;
      end else begin
         unique case (r_state)
            R_IDLE: if (req_i.ar_valid) begin
               r_id    <= req_i.ar.id;
               r_addr  <= req_i.ar.addr;
               r_len   <= req_i.ar.len;
               r_size  <= req_i.ar.size;
               r_burst <= req_i.ar.burst;
               r_err   <= ar_err;
               r_cnt   <= '0;
               r_data  <= rd_word;
               r_state <= R_DATA;
            end
            R_DATA: if (req_i.r_ready) begin
               r_addr <= rd_addr;
               r_cnt  <= r_cnt + 8'd1;
               r_data <= rd_word;
               if (r_cnt == r_len) r_state <= R_IDLE;
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   always_comb begin
      resp_o = '0;
      if (!rst_i) begin
         resp_o.aw_ready = (w_state == W_IDLE);
         resp_o.w_ready  = (w_state == W_DATA);
         resp_o.b_valid  = (w_state == W_RESP);
         resp_o.b.id     = w_id;
         resp_o.b.resp   = w_err ? 2'b10 : 2'b00;
         resp_o.ar_ready = (r_state == R_IDLE);
         resp_o.r_valid  = (r_state == R_DATA);
         resp_o.r.id     = r_id;
         resp_o.r.data   = r_data;
         resp_o.r.resp   = r_err ? 2'b10 : 2'b00;
         resp_o.r.last   = (r_cnt == r_len);
      end
   end

   logic unused_fields;
   assign unused_fields = ^{req_i.aw.lock, req_i.aw.cache, req_i.aw.prot,
                            req_i.aw.qos, req_i.aw.region, req_i.aw.user,
                            req_i.ar.lock, req_i.ar.cache, req_i.ar.prot,
                            req_i.ar.qos, req_i.ar.region, req_i.ar.user,
                            req_i.w.user};

endmodule
